// File: rtl/game_pkg.sv
// Shared key constants, PS/2 prefix bytes and decoder state type for the
// keyboard front end and the motion engine.
package game_pkg;

  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_NONE  = 8'h00;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXT_BRK} dec_state_e;
  typedef enum logic [1:0] {DIR_NONE, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;

  // One-hot in the held layout {up, down, left, right}; zero for non-arrows.
  function automatic logic [3:0] arrowMask(input logic [7:0] code);
    case (code)
      KEY_UP:    return 4'b1000;
      KEY_DOWN:  return 4'b0100;
      KEY_LEFT:  return 4'b0010;
      KEY_RIGHT: return 4'b0001;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic dir_e dirOf(input logic [3:0] mask);
    case (mask)
      4'b0100: return DIR_DOWN;
      4'b0010: return DIR_LEFT;
      4'b0001: return DIR_RIGHT;
      default: return DIR_NONE;
    endcase
  endfunction

  function automatic logic [3:0] dirMask(input dir_e dir);
    case (dir)
      DIR_DOWN:  return 4'b0100;
      DIR_LEFT:  return 4'b0010;
      DIR_RIGHT: return 4'b0001;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic logic [7:0] dirCode(input dir_e dir);
    case (dir)
      DIR_DOWN:  return KEY_DOWN;
      DIR_LEFT:  return KEY_LEFT;
      DIR_RIGHT: return KEY_RIGHT;
      default:   return KEY_NONE;
    endcase
  endfunction

  // Highest-priority still-held direction: right > left > down.
  function automatic dir_e pickFallback(input logic [3:0] heldMask);
    if (heldMask[0]) return DIR_RIGHT;
    if (heldMask[1]) return DIR_LEFT;
    if (heldMask[2]) return DIR_DOWN;
    return DIR_NONE;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider producing a registered one-cycle pulse every DIV cycles;
// the first pulse follows the DIV-th clock edge after reset release.
module tick_divider #(
  parameter int DIV = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic         tick_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + W'(1);
      tick_q <= 1'b0;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/move_cmd_scheduler.sv
// Decodes PS/2 arrow make/break sequences, tracks held keys and arbitrates a
// single registered keycode for the motion engine, with a tick-limited jump.
module move_cmd_scheduler
  import game_pkg::*;
#(
  parameter int TICK_DIV       = 1000000,
  parameter int PREFIX_TIMEOUT = 50000,
  parameter int JUMP_TICKS     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  output logic [7:0] keycode,
  output logic [3:0] held,
  output logic       jump_active,
  output logic       frame_tick
);

  localparam int TW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam int JW = $clog2(JUMP_TICKS + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(PREFIX_TIMEOUT - 1);
  localparam logic [JW-1:0] JUMP_LOAD = JW'(JUMP_TICKS);

  dec_state_e    state_q, state_d;
  logic [TW-1:0] toCnt_q, toCnt_d;
  logic [3:0]    held_q, held_d;
  dir_e          lastDir_q, lastDir_d;
  logic          armed_q, armed_d;
  logic [JW-1:0] jumpCnt_q, jumpCnt_d;
  logic [7:0]    keycode_q, keycode_d;
  logic [3:0]    mask;
  logic          makeEv, breakEv;

  tick_divider #(.DIV(TICK_DIV)) uTickDiv (
    .clk_i  (clk),
    .rst_i  (rst),
    .tick_o (frame_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= D_IDLE;
      toCnt_q <= '0;
    end else begin
      state_q <= state_d;
      toCnt_q <= toCnt_d;
    end
  end

  // Prefix decoder; a stalled prefix is abandoned after PREFIX_TIMEOUT idle cycles.
  always_comb begin
    state_d = state_q;
    toCnt_d = toCnt_q;
    makeEv  = 1'b0;
    breakEv = 1'b0;
    mask    = arrowMask(scan_code);
    if (scan_valid) begin
      toCnt_d = '0;
      unique case (state_q)
        D_IDLE: begin
          if (scan_code == PS2_EXT)      state_d = D_EXT;
          else if (scan_code == PS2_BRK) state_d = D_BRK;
        end
        D_EXT: begin
          if (scan_code == PS2_BRK) begin
            state_d = D_EXT_BRK;
          end else begin
            state_d = D_IDLE;
            makeEv  = (mask != 4'b0000);
          end
        end
        D_EXT_BRK: begin
          state_d = D_IDLE;
          breakEv = (mask != 4'b0000);
        end
        D_BRK:   state_d = D_IDLE;
        default: state_d = D_IDLE;
      endcase
    end else if (state_q != D_IDLE) begin
      if (toCnt_q == TO_LAST) begin
        state_d = D_IDLE;
        toCnt_d = '0;
      end else begin
        toCnt_d = toCnt_q + TW'(1);
      end
    end else begin
      toCnt_d = '0;
    end
  end

  // Tick decrement is applied first so a fresh up press can override it.
  always_comb begin
    held_d    = held_q;
    lastDir_d = lastDir_q;
    armed_d   = armed_q;
    jumpCnt_d = jumpCnt_q;
    if (frame_tick && armed_q) begin
      jumpCnt_d = (jumpCnt_q == '0) ? '0 : jumpCnt_q - JW'(1);
      if (jumpCnt_q <= JW'(1)) armed_d = 1'b0;
    end
    if (makeEv) begin
      held_d = held_q | mask;
      if (mask[3]) begin
        if (!held_q[3]) begin
          armed_d   = 1'b1;
          jumpCnt_d = JUMP_LOAD;
        end
      end else begin
        lastDir_d = dirOf(mask);
      end
    end
    if (breakEv) begin
      held_d = held_q & ~mask;
      if (mask[3]) begin
        armed_d   = 1'b0;
        jumpCnt_d = '0;
      end else if (dirOf(mask) == lastDir_q) begin
        lastDir_d = pickFallback(held_d);
      end
    end
    if (armed_d)                                keycode_d = KEY_UP;
    else if ((held_d & dirMask(lastDir_d)) != 0) keycode_d = dirCode(lastDir_d);
    else                                        keycode_d = KEY_NONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q    <= '0;
      lastDir_q <= DIR_NONE;
      armed_q   <= 1'b0;
      jumpCnt_q <= '0;
      keycode_q <= KEY_NONE;
    end else begin
      held_q    <= held_d;
      lastDir_q <= lastDir_d;
      armed_q   <= armed_d;
      jumpCnt_q <= jumpCnt_d;
      keycode_q <= keycode_d;
    end
  end

  assign keycode     = keycode_q;
  assign held        = held_q;
  assign jump_active = armed_q;

endmodule

// File: tb/tb_move_cmd_scheduler.sv
// Directed and randomized checks of move_cmd_scheduler against a key-event
// reference model kept in this bench.
module tb_move_cmd_scheduler;

  localparam int TICK_DIV       = 5;
  localparam int PREFIX_TIMEOUT = 20;
  localparam int JUMP_TICKS     = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scanValid = 1'b0;
  logic [7:0] scanCode = 8'h00;
  logic [7:0] keycode;
  logic [3:0] held;
  logic       jumpActive;
  logic       frameTick;

  int checks = 0;
  int failures = 0;

  // Reference model: held[3]=up, [2]=down, [1]=left, [0]=right.
  bit         mHeld[4];
  int         mLast;
  bit         mArmed;
  int         mJcnt;
  logic [7:0] mPend[$];
  int         mIdle;
  int         mEdges;
  bit         mTick;

  move_cmd_scheduler #(
    .TICK_DIV       (TICK_DIV),
    .PREFIX_TIMEOUT (PREFIX_TIMEOUT),
    .JUMP_TICKS     (JUMP_TICKS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scan_valid  (scanValid),
    .scan_code   (scanCode),
    .keycode     (keycode),
    .held        (held),
    .jump_active (jumpActive),
    .frame_tick  (frameTick)
  );

  always #5 clk = ~clk;

  function automatic int keyIndex(input logic [7:0] c);
    case (c)
      8'h75:   return 3;
      8'h72:   return 2;
      8'h6B:   return 1;
      8'h74:   return 0;
      default: return -1;
    endcase
  endfunction

  function automatic logic [7:0] codeOf(input int i);
    case (i)
      3:       return 8'h75;
      2:       return 8'h72;
      1:       return 8'h6B;
      default: return 8'h74;
    endcase
  endfunction

  function automatic logic [7:0] expKey();
    if (mArmed) return 8'h75;
    if (mLast >= 0 && mHeld[mLast]) return codeOf(mLast);
    return 8'h00;
  endfunction

  function automatic logic [3:0] expHeld();
    return {mHeld[3], mHeld[2], mHeld[1], mHeld[0]};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 4; i++) mHeld[i] = 1'b0;
    mLast = -1; mArmed = 1'b0; mJcnt = 0;
    mPend.delete(); mIdle = 0; mEdges = 0; mTick = 1'b0;
  endtask

  task automatic modelMake(input int k);
    if (k == 3) begin
      if (!mHeld[3]) begin mArmed = 1'b1; mJcnt = JUMP_TICKS; end
    end else begin
      mLast = k;
    end
    mHeld[k] = 1'b1;
  endtask

  task automatic modelBreak(input int k);
    mHeld[k] = 1'b0;
    if (k == 3) begin
      mArmed = 1'b0;
    end else if (mLast == k) begin
      mLast = -1;
      for (int i = 0; i < 3; i++) if (mHeld[i] && mLast < 0) mLast = i;
    end
  endtask

  task automatic modelByte(input logic [7:0] b);
    int k;
    k = keyIndex(b);
    if (mPend.size() == 0) begin
      if (b == 8'hE0 || b == 8'hF0) mPend.push_back(b);
    end else if (mPend.size() == 1 && mPend[0] == 8'hE0) begin
      if (b == 8'hF0) mPend.push_back(b);
      else begin
        if (k >= 0) modelMake(k);
        mPend.delete();
      end
    end else begin
      if (mPend.size() == 2 && k >= 0) modelBreak(k);
      mPend.delete();
    end
  endtask

  task automatic modelEdge(input logic valid, input logic [7:0] b);
    if (mTick && mArmed) begin
      mJcnt--;
      if (mJcnt == 0) mArmed = 1'b0;
    end
    if (valid) begin
      mIdle = 0;
      modelByte(b);
    end else if (mPend.size() != 0) begin
      mIdle++;
      if (mIdle >= PREFIX_TIMEOUT) begin mPend.delete(); mIdle = 0; end
    end else begin
      mIdle = 0;
    end
    mEdges++;
    mTick = (mEdges % TICK_DIV) == 0;
  endtask

  task automatic checkOutput();
    checks++;
    assert (keycode === expKey()) else begin
      failures++;
      $error("[TB] FAIL keycode: observed %h expected %h (t=%0t)", keycode, expKey(), $time);
    end
    checks++;
    assert (held === expHeld()) else begin
      failures++;
      $error("[TB] FAIL held: observed %b expected %b (t=%0t)", held, expHeld(), $time);
    end
    checks++;
    assert (jumpActive === mArmed) else begin
      failures++;
      $error("[TB] FAIL jump_active: observed %b expected %b (t=%0t)", jumpActive, mArmed, $time);
    end
    checks++;
    assert (frameTick === mTick) else begin
      failures++;
      $error("[TB] FAIL frame_tick: observed %b expected %b (t=%0t)", frameTick, mTick, $time);
    end
  endtask

  task automatic checkConst(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Called at a falling edge; drives one cycle, checks after the rising edge.
  task automatic applyStimulus(input logic valid, input logic [7:0] code);
    scanValid = valid;
    scanCode  = code;
    @(posedge clk);
    modelEdge(valid, code);
    #1;
    checkOutput();
    @(negedge clk);
    scanValid = 1'b0;
  endtask

  task automatic applyIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
  endtask

  task automatic sendMake(input logic [7:0] code);
    applyStimulus(1'b1, 8'hE0);
    applyStimulus(1'b1, code);
  endtask

  task automatic sendBreak(input logic [7:0] code);
    applyStimulus(1'b1, 8'hE0);
    applyStimulus(1'b1, 8'hF0);
    applyStimulus(1'b1, code);
  endtask

  // Reset is raised between clock edges to exercise the asynchronous path.
  task automatic applyReset();
    scanValid = 1'b0;
    #2 rst = 1'b1;
    modelReset();
    #1;
    checkOutput();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int tickSeen;
    int guard;
    logic [7:0] pick;
    modelReset();
    @(negedge clk);
    applyReset();

    $display("[TB] frame tick cadence");
    for (int n = 1; n <= 16; n++) begin
      applyStimulus(1'b0, 8'h00);
      checkConst("frame_tick_cycle", {7'd0, frameTick}, (n % TICK_DIV == 0) ? 8'h01 : 8'h00);
    end

    $display("[TB] reset mid-prefix");
    applyStimulus(1'b1, 8'hE0);
    applyReset();
    applyStimulus(1'b1, 8'h75);
    checkConst("after_reset_held", {4'd0, held}, 8'h00);
    checkConst("after_reset_key", keycode, 8'h00);

    $display("[TB] make/break right");
    sendMake(8'h74);
    checkConst("make_right_held", {4'd0, held}, 8'h01);
    checkConst("make_right_key", keycode, 8'h74);
    sendBreak(8'h74);
    checkConst("break_right_held", {4'd0, held}, 8'h00);
    checkConst("break_right_key", keycode, 8'h00);

    $display("[TB] recency");
    sendMake(8'h74);
    sendMake(8'h6B);
    checkConst("recent_left", keycode, 8'h6B);
    sendBreak(8'h6B);
    checkConst("fallback_right", keycode, 8'h74);
    sendMake(8'h72);
    sendMake(8'h74);
    sendBreak(8'h74);
    checkConst("fallback_down", keycode, 8'h72);
    sendBreak(8'h72);
    checkConst("all_released", keycode, 8'h00);

    $display("[TB] jump limit");
    sendMake(8'h74);
    sendMake(8'h75);
    checkConst("jump_start", keycode, 8'h75);
    tickSeen = (jumpActive && frameTick) ? 1 : 0;
    guard = 0;
    while (jumpActive && guard < 100) begin
      applyStimulus(1'b0, 8'h00);
      if (jumpActive && frameTick) tickSeen++;
      guard++;
    end
    checkConst("jump_ended_in_time", {7'd0, jumpActive}, 8'h00);
    checkConst("jump_tick_count", 8'(tickSeen), 8'(JUMP_TICKS));
    checkConst("after_jump_key", keycode, 8'h74);
    sendMake(8'h75);
    sendMake(8'h75);
    checkConst("typematic_no_rearm", keycode, 8'h74);
    sendBreak(8'h75);
    sendMake(8'h75);
    checkConst("rearm_after_release", keycode, 8'h75);
    sendBreak(8'h75);
    sendBreak(8'h74);

    $display("[TB] prefix timeout");
    applyStimulus(1'b1, 8'hE0);
    applyIdle(PREFIX_TIMEOUT);
    applyStimulus(1'b1, 8'h74);
    checkConst("timeout_ignored", {4'd0, held}, 8'h00);
    applyStimulus(1'b1, 8'hE0);
    applyIdle(PREFIX_TIMEOUT - 1);
    applyStimulus(1'b1, 8'h74);
    checkConst("just_before_timeout", {4'd0, held}, 8'h01);
    sendBreak(8'h74);

    $display("[TB] reset mid-jump");
    sendMake(8'h75);
    applyIdle(2);
    applyReset();
    applyIdle(3);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        applyReset();
      end else if ($urandom_range(0, 59) == 0) begin
        applyIdle($urandom_range(PREFIX_TIMEOUT - 3, PREFIX_TIMEOUT + 3));
      end else if ($urandom_range(0, 9) < 4) begin
        case ($urandom_range(0, 7))
          0, 1:    pick = 8'hE0;
          2:       pick = 8'hF0;
          3:       pick = 8'h75;
          4:       pick = 8'h72;
          5:       pick = 8'h6B;
          6:       pick = 8'h74;
          default: pick = 8'($urandom);
        endcase
        applyStimulus(1'b1, pick);
      end else begin
        applyStimulus(1'b0, 8'h00);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_cmd_scheduler.md
# move_cmd_scheduler

Converts the raw PS/2 scan-byte stream into the single arbitrated 8-bit keycode consumed by the character-motion engine. It also produces that engine's frame tick. It sits between the PS/2 receiver and the motion datapath. It decodes E0/F0 prefixes, tracks the held state of the four arrow keys, and picks one command per cycle. Jumps are rate-limited to one per key press.

## Interface
- TICK_DIV, 1000000: clk cycles per frame_tick pulse.
- PREFIX_TIMEOUT, 50000: clk cycles a prefix state may wait for its next byte before being abandoned.
- JUMP_TICKS, 8: frame ticks for which KEY_UP is presented after an up press.
- clk  in  1  system clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- scan_valid  in  1  one-cycle strobe: scan_code holds a new byte.
- scan_code  in  8  byte from the PS/2 receiver.
- keycode  out  8  arbitrated command: 0x75 up, 0x72 down, 0x6B left, 0x74 right, 0x00 none.
- held  out  4  held flags {up, down, left, right}.
- jump_active  out  1  KEY_UP is currently being presented.
- frame_tick  out  1  one-cycle pulse every TICK_DIV cycles.

## Operation
- **Decoder FSM states:** D_IDLE, D_EXT (after E0), D_BRK (after F0), D_EXT_BRK (after E0 F0).
- **Transitions on scan_valid:**
  - D_IDLE: E0 goes to D_EXT; F0 goes to D_BRK; any other byte is ignored.
  - D_EXT: F0 goes to D_EXT_BRK; an arrow code is a make event and returns to D_IDLE; any other byte returns to D_IDLE with no effect.
  - D_EXT_BRK: an arrow code is a break event and returns to D_IDLE; any other byte returns to D_IDLE.
  - D_BRK: any byte returns to D_IDLE. Non-extended keys are ignored.
- **Prefix timeout:** in any non-IDLE state, a counter runs. When PREFIX_TIMEOUT cycles pass without scan_valid, the FSM returns to D_IDLE with no event. The counter clears on every scan_valid.
- **Make event:** sets the key's held bit.
  - For down, left or right, the key also becomes last_dir.
  - For up: if up was not already held (not a typematic repeat), set jump_armed and load jump_cnt = JUMP_TICKS.
- **Break event:** clears the key's held bit.
  - If the key was last_dir, last_dir falls back to the highest-priority remaining held key (right > left > down), or none.
  - An up break clears jump_armed.
- **Jump timer:** while jump_armed, each frame_tick decrements jump_cnt. At 0, jump_armed clears. It stays clear until up is released and pressed again; typematic up makes do not re-arm.
- **Arbitration:** keycode = KEY_UP if jump_armed; else the code of last_dir if it is held; else 0x00.
- **Simultaneous events:** a make/break event and a frame_tick in the same cycle are both applied. A make on up loads JUMP_TICKS and overrides the decrement.

## Timing
- Reset values: keycode 0x00, held 0, jump_active 0, frame_tick 0. The FSM goes to D_IDLE and all counters clear.
- Reset is asynchronous and may assert mid-prefix or mid-jump. State is lost and nothing completes after release.
- **Latency:** held, keycode and jump_active update on the clk edge after the scan_valid cycle that carries the final byte (1 cycle).
- **frame_tick:** first pulse on cycle TICK_DIV after reset release, then every TICK_DIV cycles. Divider width is clog2(TICK_DIV); it wraps to 0 on the pulse.
- jump_cnt is clog2(JUMP_TICKS+1) bits wide and saturates at 0.
- keycode is registered and glitch-free. The engine samples it on its own tick.

## Structure
- Shared package `game_pkg`: arrow keycode constants (KEY_UP/DOWN/LEFT/RIGHT), PS/2 prefix constants (0xE0, 0xF0), and the decoder-state enum. The motion engine imports the same key constants.
- Sub-module `tick_divider` (parameter DIV, outputs a pulse) generates frame_tick. All other logic stays in this module.

## Test plan
- **Reset:** assert rst mid-stream after E0 -> all outputs 0; next byte 75 alone produces no event.
- **Make/break right:** E0 74 -> held=0001, keycode=0x74 one cycle later; E0 F0 74 -> held=0000, keycode=0x00.
- **Recency:**
  - E0 74, then E0 6B -> keycode 0x6B.
  - Break 6B -> keycode 0x74.
  - Break 74 with down held -> keycode 0x72.
- **Jump limit:** JUMP_TICKS=3 with right held, E0 75 -> keycode 0x75 for 3 frame ticks then 0x74.
  - Repeated E0 75 makes -> no re-arm.
  - Break, then E0 75 -> 0x75 again.
- **Timeout:** E0 then idle PREFIX_TIMEOUT cycles, then 74 -> ignored, held stays 0.
- **Tick:** TICK_DIV=5 -> frame_tick high on cycles 5, 10, 15 after reset release, low on all other cycles.
